// File: rtl/rcp_iter_ctrl.sv
// Sequential unsigned reciprocal: floor(2^WIDTH / a), saturated, via one time-multiplexed
// Newton-Raphson stage. Define RCP_EARLY_EXIT_EN to leave ITER as soon as the estimate converges.
module rcp_iter_ctrl #(
  parameter int WIDTH = 16,
  parameter int ITERS = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] est_o,
  output logic             div0_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o
);
  localparam int CW = $clog2(ITERS + 1);
  localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      LAST   = CW'(ITERS - 1);
  localparam logic [WIDTH+1:0]   TWO_W1 = (WIDTH+2)'(1) << (WIDTH + 1);
  localparam logic [2*WIDTH:0]   LIM    = (2*WIDTH+1)'(1) << WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_CORRECT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, est_q;
  logic [CW-1:0]    cnt_q;

  // Seed: one power of two below the true reciprocal keeps a*est under 2^(WIDTH+1).
  logic [LW-1:0]    lead;
  logic [WIDTH-1:0] seed;
  always_comb begin
    lead = '0;
    for (int i = 0; i < WIDTH; i++)
      if (a_i[i]) lead = LW'(i);
    seed = WIDTH'(1) << (LW'(WIDTH - 1) - lead);
  end

  // Newton stage: est' = est * (2^(W+1) - a*est) >> W
  logic [2*WIDTH-1:0] ae;
  logic [WIDTH+1:0]   resid;
  logic [2*WIDTH+1:0] prod;
  logic [WIDTH-1:0]   stage;
  assign ae    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, est_q};
  assign resid = TWO_W1 - ae[WIDTH+1:0];
  assign prod  = {{(WIDTH+2){1'b0}}, est_q} * {{WIDTH{1'b0}}, resid};
  assign stage = prod[2*WIDTH-1:WIDTH];

  // Final +1 correction: the iterate is q or q-1 here.
  logic [WIDTH:0]   est_p1;
  logic [2*WIDTH:0] corr_prod;
  logic             corr_ok;
  assign est_p1    = {1'b0, est_q} + 1'b1;
  assign corr_prod = (2*WIDTH+1)'(a_q) * (2*WIDTH+1)'(est_p1);
  assign corr_ok   = (corr_prod <= LIM);

  logic unused_bits;
  assign unused_bits = ^{ae[2*WIDTH-1:WIDTH+2], prod[2*WIDTH+1:2*WIDTH], prod[WIDTH-1:0], est_p1[WIDTH]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (in_valid_i) state_d = (a_i <= WIDTH'(1)) ? S_DONE : S_ITER;
      S_ITER: begin
`ifdef RCP_EARLY_EXIT_EN
        if (cnt_q == LAST || stage == est_q) state_d = S_CORRECT;
`else
        if (cnt_q == LAST) state_d = S_CORRECT;
`endif
      end
      S_CORRECT: state_d = S_DONE;
      S_DONE:
        if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == S_IDLE);
    out_valid_o = (state_q == S_DONE);
    busy_o      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      est_q  <= '0;
      cnt_q  <= '0;
      est_o  <= '0;
      div0_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:
          if (in_valid_i) begin
            a_q    <= a_i;
            div0_o <= (a_i == '0);
            if (a_i <= WIDTH'(1)) begin
              est_o <= '1;
            end else begin
              est_q <= seed;
              cnt_q <= '0;
            end
          end
        S_ITER: begin
          est_q <= stage;
          cnt_q <= cnt_q + 1'b1;
        end
        S_CORRECT:
          est_o <= corr_ok ? est_p1[WIDTH-1:0] : est_q;
        default: ;
      endcase
    end
  end
endmodule
